// File: rtl/spike_arb_pkg.sv
// rtl/spike_arb_pkg.sv - shared constants and event type for the spike event arbiter
//
// Purpose: arbitration mode encodings, default field widths and the spike
// event record. The widths here are the defaults. Modules take their own
// width parameters and override these defaults where needed.
package spike_arb_pkg;

  localparam logic ARB_MODE_RR    = 1'b0;
  localparam logic ARB_MODE_FIXED = 1'b1;

  localparam int DEF_NEURON_ID_W = 4;
  localparam int DEF_TS_W        = 8;

  typedef struct packed {
    logic [DEF_NEURON_ID_W-1:0] id;
    logic [DEF_TS_W-1:0]        ts;
  } spike_event_t;

endpackage

// File: rtl/spike_event_fifo.sv
// rtl/spike_event_fifo.sv - synchronous spike event FIFO with registered head
//
// Purpose: buffers granted {id, ts} events between the arbiter and the router.
// The head fields come straight from flops, so they stay stable while the
// entry waits for downstream acceptance.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push_i, push_*_i write one event (ignored when full)
//   pop_i            drop the head event (ignored when empty)
//   head_id_o/ts_o   registered head event fields
//   count_o          current occupancy, 0..DEPTH
module spike_event_fifo #(
  parameter int ID_W  = 4,
  parameter int TS_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [ID_W-1:0]          push_id_i,
  input  logic [TS_W-1:0]          push_ts_i,
  input  logic                     pop_i,
  output logic [ID_W-1:0]          head_id_o,
  output logic [TS_W-1:0]          head_ts_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [ID_W-1:0] id_mem_q [DEPTH];
  logic [TS_W-1:0] ts_mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [AW:0]     count_q, count_d;
  logic [ID_W-1:0] head_id_q, head_id_d;
  logic [TS_W-1:0] head_ts_q, head_ts_d;
  logic            do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (count_q != (AW+1)'(DEPTH));
  assign rd_nxt  = rd_ptr_q + AW'(1);

  always_comb begin
    count_d   = count_q;
    head_id_d = head_id_q;
    head_ts_d = head_ts_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // The head register is reloaded when the current head leaves, or when
    // an event lands in an empty FIFO. With one entry left and a push in the
    // same cycle, the incoming event becomes the head directly.
    if (do_pop) begin
      if (count_q == (AW+1)'(1)) begin
        if (do_push) begin
          head_id_d = push_id_i;
          head_ts_d = push_ts_i;
        end
      end else begin
        head_id_d = id_mem_q[rd_nxt];
        head_ts_d = ts_mem_q[rd_nxt];
      end
    end else if (do_push && (count_q == '0)) begin
      head_id_d = push_id_i;
      head_ts_d = push_ts_i;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      id_mem_q[wr_ptr_q] <= push_id_i;
      ts_mem_q[wr_ptr_q] <= push_ts_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      head_id_q <= '0;
      head_ts_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_nxt;
      count_q   <= count_d;
      head_id_q <= head_id_d;
      head_ts_q <= head_ts_d;
    end
  end

  assign head_id_o = head_id_q;
  assign head_ts_o = head_ts_q;
  assign count_o   = count_q;

endmodule

// File: rtl/spike_event_arbiter.sv
// rtl/spike_event_arbiter.sv - round-robin / fixed-priority spike request arbiter
//
// Purpose: picks one requesting neuron per cycle and tags the grant with the
// current timestep. The tagged event is pushed into an output FIFO.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mode            0 round-robin, 1 fixed priority (lowest index wins)
//   timestep_tick   advance cur_ts (wraps)
//   req_valid       per-neuron request, held until granted
//   req_grant       one-hot combinational grant
//   spike_valid/id/ts, spike_ready   output event stream (FIFO head)
//   fifo_level      FIFO occupancy
//   cur_ts          current timestep counter
module spike_event_arbiter
  import spike_arb_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int NEURON_ID_W = DEF_NEURON_ID_W,
  parameter int TS_W        = DEF_TS_W,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic                          timestep_tick,
  input  logic [NUM_NEURONS-1:0]        req_valid,
  output logic [NUM_NEURONS-1:0]        req_grant,
  output logic                          spike_valid,
  output logic [NEURON_ID_W-1:0]        spike_id,
  output logic [TS_W-1:0]               spike_ts,
  input  logic                          spike_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [TS_W-1:0]               cur_ts
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [NEURON_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TS_W-1:0]        cur_ts_q, cur_ts_d;
  logic                   can_push;
  logic                   grant_any;
  logic [NEURON_ID_W-1:0] grant_idx;
  logic [NEURON_ID_W:0]   cand;

  // A pop in the same cycle does not free a slot; this keeps spike_ready
  // out of the grant path.
  assign can_push = (fifo_level < LW'(FIFO_DEPTH));

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    req_grant = '0;
    cand      = '0;
    if (!rst && can_push) begin
      if (mode == ARB_MODE_FIXED) begin
        // Descending scan: the last hit is the lowest requesting index.
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
          if (req_valid[i]) begin
            grant_any = 1'b1;
            grant_idx = NEURON_ID_W'(i);
          end
        end
      end else begin
        // Offsets are scanned from NUM_NEURONS down to 1, so the final hit is
        // the first requester after rr_ptr. rr_ptr + k < 2*NUM_NEURONS, so one
        // conditional subtract wraps the index into 0..NUM_NEURONS-1.
        for (int k = NUM_NEURONS; k >= 1; k--) begin
          cand = {1'b0, rr_ptr_q} + (NEURON_ID_W+1)'(k);
          if (cand >= (NEURON_ID_W+1)'(NUM_NEURONS)) begin
            cand = cand - (NEURON_ID_W+1)'(NUM_NEURONS);
          end
          if (req_valid[cand[NEURON_ID_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[NEURON_ID_W-1:0];
          end
        end
      end
      if (grant_any) req_grant[grant_idx] = 1'b1;
    end
  end

  // rr_ptr follows every winner, so a switch back to round-robin resumes
  // after whoever won last in fixed mode.
  assign rr_ptr_d = grant_any ? grant_idx : rr_ptr_q;
  assign cur_ts_d = timestep_tick ? cur_ts_q + TS_W'(1) : cur_ts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= NEURON_ID_W'(NUM_NEURONS - 1);
      cur_ts_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cur_ts_q <= cur_ts_d;
    end
  end

  spike_event_fifo #(
    .ID_W  (NEURON_ID_W),
    .TS_W  (TS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (grant_any),
    .push_id_i (grant_idx),
    .push_ts_i (cur_ts_q),
    .pop_i     (spike_ready),
    .head_id_o (spike_id),
    .head_ts_o (spike_ts),
    .count_o   (fifo_level)
  );

  assign spike_valid = (fifo_level != '0);
  assign cur_ts      = cur_ts_q;

endmodule

// File: tb/tb_spike_event_arbiter.sv
// tb/tb_spike_event_arbiter.sv - self-checking bench for spike_event_arbiter
module tb_spike_event_arbiter;
  import spike_arb_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  mode, tick, ready;
  logic [15:0] rq [2];

  logic [15:0] g0;
  logic [4:0]  g1;
  logic        v0, v1;
  logic [3:0]  id0;
  logic [2:0]  id1;
  logic [7:0]  ts0, cts0;
  logic [1:0]  ts1, cts1;
  logic [2:0]  lv0, lv1;

  spike_event_arbiter #(.NUM_NEURONS(16), .NEURON_ID_W(4), .TS_W(8), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(rst), .mode(mode[0]), .timestep_tick(tick[0]), .req_valid(rq[0]),
    .req_grant(g0), .spike_valid(v0), .spike_id(id0), .spike_ts(ts0),
    .spike_ready(ready[0]), .fifo_level(lv0), .cur_ts(cts0));

  spike_event_arbiter #(.NUM_NEURONS(5), .NEURON_ID_W(3), .TS_W(2), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .mode(mode[1]), .timestep_tick(tick[1]), .req_valid(rq[1][4:0]),
    .req_grant(g1), .spike_valid(v1), .spike_id(id1), .spike_ts(ts1),
    .spike_ready(ready[1]), .fifo_level(lv1), .cur_ts(cts1));

  // Reference model: the FIFO is a shift array whose element 0 is the head.
  int nn  [2] = '{16, 5};
  int tsm [2] = '{256, 4};
  int m_rr [2];
  int m_ts [2];
  int m_cnt[2];
  int m_id [2][DEPTH];
  int m_tq [2][DEPTH];
  bit m_fresh[2];
  int last_g[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  function automatic int exp_grant(int d);
    if (m_cnt[d] >= DEPTH) return -1;
    if (mode[d] == ARB_MODE_FIXED) begin
      for (int i = 0; i < nn[d]; i++) if (rq[d][i]) return i;
    end else begin
      for (int k = 1; k <= nn[d]; k++) if (rq[d][(m_rr[d] + k) % nn[d]]) return (m_rr[d] + k) % nn[d];
    end
    return -1;
  endfunction

  task automatic model_reset(input int d);
    m_cnt[d]   = 0;
    m_rr[d]    = nn[d] - 1;
    m_ts[d]    = 0;
    m_fresh[d] = 1'b1;
  endtask

  // Inputs are set at the negedge; outputs are checked 1 time unit later,
  // the model advances at the posedge and the task returns at the next negedge.
  task automatic cycle(input logic r);
    int g[2];
    rst = r;
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [31:0] og, ov, oid, ots, olv, octs;
      if (d == 0) begin
        og = 32'(g0); ov = 32'(v0); oid = 32'(id0); ots = 32'(ts0); olv = 32'(lv0); octs = 32'(cts0);
      end else begin
        og = 32'(g1); ov = 32'(v1); oid = 32'(id1); ots = 32'(ts1); olv = 32'(lv1); octs = 32'(cts1);
      end
      g[d] = r ? -1 : exp_grant(d);
      chk("req_grant", d, og, (g[d] < 0) ? 32'd0 : (32'd1 << g[d]));
      chk("spike_valid", d, ov, 32'(m_cnt[d] != 0));
      if (m_cnt[d] != 0) begin
        chk("spike_id", d, oid, 32'(m_id[d][0]));
        chk("spike_ts", d, ots, 32'(m_tq[d][0]));
      end else if (m_fresh[d]) begin
        chk("spike_id_rst", d, oid, 32'd0);
        chk("spike_ts_rst", d, ots, 32'd0);
      end
      chk("fifo_level", d, olv, 32'(m_cnt[d]));
      chk("cur_ts", d, octs, 32'(m_ts[d]));
      last_g[d] = g[d];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        model_reset(d);
      end else begin
        if (m_cnt[d] > 0 && ready[d]) begin
          for (int i = 0; i < DEPTH - 1; i++) begin
            m_id[d][i] = m_id[d][i+1];
            m_tq[d][i] = m_tq[d][i+1];
          end
          m_cnt[d]--;
        end
        if (g[d] >= 0) begin
          m_id[d][m_cnt[d]] = g[d];
          m_tq[d][m_cnt[d]] = m_ts[d];
          m_cnt[d]++;
          m_rr[d]    = g[d];
          m_fresh[d] = 1'b0;
        end
        if (tick[d]) m_ts[d] = (m_ts[d] + 1) % tsm[d];
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; tick = 2'b00; ready = 2'b00;
    rq[0] = 16'h0; rq[1] = 16'h0;
    @(negedge clk);
    @(posedge clk);
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    cycle(1'b1);

    // RR alternation on dut0; single requester with periodic tick on dut1.
    rq[0] = 16'h0005; rq[1] = 16'h0001; ready = 2'b11;
    for (int i = 0; i < 12; i++) begin
      tick[1] = (i % 3 == 2);
      cycle(1'b0);
      chk("rr_alt", 0, 32'(last_g[0]), (i % 2 == 1) ? 32'd2 : 32'd0);
      chk("single_req", 1, 32'(last_g[1]), 32'd0);
    end
    tick = 2'b00;

    // Fill with downstream stalled; dut1 shows the 5-neuron RR order.
    rq[0] = 16'hFFFF; ready = 2'b10; rq[1] = 16'h001F;
    cycle(1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0);
      chk("fill_grant", 0, 32'(last_g[0]), (i < 4) ? 32'(i) : 32'hFFFF_FFFF);
      chk("n5_order", 1, 32'(last_g[1]), 32'(i % 5));
    end
    chk("full_level", 0, 32'(lv0), 32'd4);
    ready[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0);
      chk("drain_grant", 0, 32'(last_g[0]), (i == 0) ? 32'hFFFF_FFFF : 32'(3 + i));
    end

    // Fixed priority, then switch back to round-robin.
    mode[0] = ARB_MODE_FIXED; rq[0] = 16'h8011; ready = 2'b11;
    cycle(1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0);
      chk("fixed_grant", 0, 32'(last_g[0]), 32'd0);
    end
    mode[0] = ARB_MODE_RR;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      chk("rr_resume", 0, 32'(last_g[0]), (i == 0) ? 32'd4 : (i == 1) ? 32'd15 : 32'd0);
    end

    // Reset with events buffered and requests pending.
    cycle(1'b1);
    rq[0] = 16'h00F0; ready[0] = 1'b0; tick = 2'b11;
    for (int i = 0; i < 3; i++) cycle(1'b0);
    chk("pre_rst_level", 0, 32'(lv0), 32'd3);
    cycle(1'b1);
    chk("rst_level", 0, 32'(lv0), 32'd0);
    chk("rst_valid", 0, 32'(v0), 32'd0);
    chk("rst_cur_ts", 0, 32'(cts0), 32'd0);
    cycle(1'b0);
    chk("post_rst_grant", 0, 32'(last_g[0]), 32'd4);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rq[0] = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rq[0] = rq[0] & 16'($urandom) & 16'($urandom);
      rq[1] = 16'($urandom_range(0, 31));
      mode  = 2'($urandom);
      tick  = 2'($urandom);
      ready = 2'($urandom);
      cycle(1'($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
